// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes PLL lock, filters it, then releases
// core and peripheral resets in a fixed, staggered order.
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 16,
  parameter int HOLD_CYCLES    = 64,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       SW_RESET,
  output logic       CORE_RESET_N,
  output logic       PERIPH_RESET_N,
  output logic       READY,
  output logic [7:0] LOCK_LOSS_CNT
);

  localparam int MAX_FH =
    (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int CNT_MAX =
    (MAX_FH > STAGGER_CYCLES) ? MAX_FH : STAGGER_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    FILTER,
    HOLD,
    STAGGER,
    RUN
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   lost;
  logic                   core_d;
  logic                   periph_d;
  logic [7:0]             loss_d;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // PLL lock synchronizer; the only reader of the raw lock input
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PLL_LOCK};
    end
  end

  // Next state, shared counter and registered-output inputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lost     = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          if (LOCK_FILTER == 1) begin
            state_d = HOLD;
          end else begin
            state_d = FILTER;
            cnt_d   = ONE;
          end
        end
      end
      FILTER: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (cnt_q == FILT_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (SW_RESET) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = STAGGER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      STAGGER: begin
        if (!lock_s) begin
          lost = 1'b1;
        end else if (SW_RESET) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == STAG_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          lost = 1'b1;
        end else if (SW_RESET) begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    if (lost) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
    core_d   = (state_d == STAGGER) ||
               (state_d == RUN);
    periph_d = (state_d == RUN);
    loss_d   = LOCK_LOSS_CNT;
    if (lost && (LOCK_LOSS_CNT != 8'hFF)) begin
      loss_d = LOCK_LOSS_CNT + 8'd1;
    end
  end

  // State, counter and all outputs come straight from flops
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= WAIT_LOCK;
      cnt_q          <= '0;
      CORE_RESET_N   <= 1'b0;
      PERIPH_RESET_N <= 1'b0;
      READY          <= 1'b0;
      LOCK_LOSS_CNT  <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      CORE_RESET_N   <= core_d;
      PERIPH_RESET_N <= periph_d;
      READY          <= periph_d;
      LOCK_LOSS_CNT  <= loss_d;
    end
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flops in the PLL_LOCK synchronizer chain; legal range 2..4.
REQ-002 Parameter LOCK_FILTER, default 16: consecutive synchronized-lock-high cycles required before lock is accepted; legal range 1..255.
REQ-003 Parameter HOLD_CYCLES, default 64: cycles the core reset is held after lock is accepted; legal range 1..1023.
REQ-004 Parameter STAGGER_CYCLES, default 8: cycles between core reset release and peripheral reset release; legal range 1..255.
REQ-005 Port CLK, input, 1: fabric clock (the PLL fabric output clock).
REQ-006 Port RESET, input, 1: reset, asynchronous and active-high.
REQ-007 Port PLL_LOCK, input, 1: raw PLL lock indication, asynchronous to CLK.
REQ-008 Port SW_RESET, input, 1: synchronous software reset request, level-sensitive.
REQ-009 Port CORE_RESET_N, output, 1: active-low reset for core logic.
REQ-010 Port PERIPH_RESET_N, output, 1: active-low reset for peripheral logic.
REQ-011 Port READY, output, 1: high only in state RUN.
REQ-012 Port LOCK_LOSS_CNT, output, 8: saturating count of lock-loss events.

Function
REQ-013 PLL_LOCK SHALL pass through a SYNC_STAGES-deep flop chain, giving lock_s; no other logic SHALL read PLL_LOCK.
REQ-014 The FSM SHALL have exactly these states: WAIT_LOCK, FILTER, HOLD, STAGGER, RUN.
REQ-015 WAIT_LOCK: when lock_s=1, go to FILTER with filter count 1.
REQ-016 FILTER: increment the count each cycle lock_s=1; at count=LOCK_FILTER, go to HOLD.
REQ-017 HOLD: count HOLD_CYCLES cycles, then go to STAGGER; CORE_RESET_N is registered high on entry to STAGGER.
REQ-018 STAGGER: count STAGGER_CYCLES cycles, then go to RUN; PERIPH_RESET_N and READY are registered high on entry to RUN.
REQ-019 Timing: with a stable lock, CORE_RESET_N SHALL rise exactly SYNC_STAGES+LOCK_FILTER+HOLD_CYCLES edges after the first CLK edge that samples PLL_LOCK=1.
REQ-020 Timing: PERIPH_RESET_N SHALL rise exactly STAGGER_CYCLES edges after CORE_RESET_N rises.
REQ-021 Lock loss: lock_s=0 in any state other than WAIT_LOCK SHALL, on the next edge, enter WAIT_LOCK, clear all counters, and drive CORE_RESET_N=0, PERIPH_RESET_N=0, READY=0.
REQ-022 Lock-loss latency SHALL be SYNC_STAGES+1 edges from the first edge that samples PLL_LOCK=0.
REQ-023 LOCK_LOSS_CNT SHALL increment by 1 on each transition from FILTER, HOLD, STAGGER or RUN into WAIT_LOCK, and SHALL saturate at 255 (no wrap).
REQ-024 SW_RESET=1 in STAGGER or RUN SHALL, on the next edge, enter HOLD with the counter cleared, driving CORE_RESET_N=0, PERIPH_RESET_N=0, READY=0.
REQ-025 SW_RESET=1 in HOLD SHALL keep the HOLD counter at 0; the HOLD count starts only once SW_RESET=0.
REQ-026 SW_RESET SHALL be ignored in WAIT_LOCK and FILTER.
REQ-027 Simultaneous lock_s=0 and SW_RESET=1: lock loss wins, i.e. the FSM enters WAIT_LOCK and LOCK_LOSS_CNT increments.
REQ-028 PERIPH_RESET_N=1 SHALL never occur while CORE_RESET_N=0.
REQ-029 All outputs SHALL be driven directly from flops (no combinational paths to outputs).
REQ-030 Counter widths SHALL be sized from the parameters; no counter SHALL wrap within its legal range.

Reset
REQ-031 While RESET=1, asynchronously and regardless of CLK: state=WAIT_LOCK, synchronizer flops=0, all counters=0, CORE_RESET_N=0, PERIPH_RESET_N=0, READY=0, LOCK_LOSS_CNT=0.
REQ-032 Release of RESET mid-sequence SHALL restart the sequence from WAIT_LOCK; LOCK_LOSS_CNT SHALL not be preserved across RESET.

Verification (defaults: SYNC=2, FILTER=16, HOLD=64, STAGGER=8)
REQ-033 Clean bring-up: PLL_LOCK rises after RESET is released -> CORE_RESET_N rises at edge 82, PERIPH_RESET_N and READY rise at edge 90, LOCK_LOSS_CNT=0.
REQ-034 Glitchy lock: PLL_LOCK high 10 cycles, low 1 cycle, then high -> filter restarts, CORE_RESET_N rises 82 edges after the final rise, LOCK_LOSS_CNT=1.
REQ-035 Lock loss in RUN: PLL_LOCK drops -> all three outputs go low at edge 3, LOCK_LOSS_CNT increments, and a full re-sequence follows once lock returns.
REQ-036 SW_RESET pulse of 5 cycles in RUN -> outputs low on the next edge; CORE_RESET_N rises 64 edges after SW_RESET falls and PERIPH_RESET_N 8 edges after that; LOCK_LOSS_CNT unchanged.
REQ-037 300 lock-loss events -> LOCK_LOSS_CNT reads 255; asynchronous RESET asserted mid-HOLD -> all outputs 0 immediately, LOCK_LOSS_CNT=0.
REQ-038 Simultaneous lock drop and SW_RESET in RUN -> state WAIT_LOCK, LOCK_LOSS_CNT+1.
